// File: rtl/clk_period_meter_if.sv
// Request/result bundle of the slow-clock period meter.
// master issues start and collects results; slave is the meter.
interface clk_period_meter_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             busy;
  logic             timeout;

  modport master (
    output start,
    input  period, high_time, valid, busy, timeout
  );

  modport slave (
    input  start,
    output period, high_time, valid, busy, timeout
  );
endinterface

// File: rtl/clk_period_meter.sv
// Measures period and high time of SlowClk in clk cycles between two rising edges.
// Result and valid appear one cycle after the terminating edge; start is ignored while busy.
module clk_period_meter #(
  parameter int          CNT_W   = 32,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SlowClk,
  clk_period_meter_if.slave bus
);

  localparam logic [CNT_W-1:0] TLAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t           state_q;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q, hcnt_q, tcnt_q;
  logic [CNT_W-1:0] cnt_d, hcnt_d, tcnt_d;
  logic [CNT_W-1:0] period_q, high_time_q;
  logic             valid_q, busy_q, timeout_q;
  logic             rise, lvl, tlast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= SlowClk;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise   = s2_q & ~s3_q;
  assign lvl    = s2_q;
  assign tlast  = (tcnt_q == TLAST);
  assign cnt_d  = cnt_q + ONE;
  assign hcnt_d = lvl ? (hcnt_q + ONE) : hcnt_q;
  assign tcnt_d = tcnt_q + ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      tcnt_q      <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            timeout_q <= 1'b0;
            tcnt_q    <= '0;
            busy_q    <= 1'b1;
            state_q   <= ARM;
          end
        end
        ARM: begin
          tcnt_q <= tcnt_d;
          if (tlast) begin
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else if (rise) begin
            // The arming edge opens the window; it already counts as one cycle.
            cnt_q   <= ONE;
            hcnt_q  <= ONE;
            state_q <= MEASURE;
          end
        end
        MEASURE: begin
          tcnt_q <= tcnt_d;
          // A closing edge beats a simultaneous timeout.
          if (rise) begin
            period_q    <= cnt_q;
            high_time_q <= hcnt_q;
            valid_q     <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else if (tlast) begin
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            cnt_q  <= cnt_d;
            hcnt_q <= hcnt_d;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.period    = period_q;
  assign bus.high_time = high_time_q;
  assign bus.valid     = valid_q;
  assign bus.busy      = busy_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench: three meters (long, 100-cycle and 60-cycle timeouts) driven by
// per-instance slow-clock pattern generators stepped on the falling clk edge.
module tb_clk_period_meter;

  localparam int V = 0, B = 1, T = 2, P = 3, H = 4;

  logic clk;
  logic rst;
  logic slow    [3];
  logic start_s [3];
  logic en      [3];
  int   gen_ph  [3];
  int   gen_per [3];
  int   gen_hi  [3];
  int   checks;
  int   errors;
  int   fv, nv, bh;

  clk_period_meter_if #(.CNT_W(32)) bus_a ();
  clk_period_meter_if #(.CNT_W(32)) bus_b ();
  clk_period_meter_if #(.CNT_W(32)) bus_c ();

  assign bus_a.start = start_s[0];
  assign bus_b.start = start_s[1];
  assign bus_c.start = start_s[2];

  clk_period_meter #(.CNT_W(32), .TIMEOUT(1000)) dut_a (
    .clk(clk), .rst(rst), .SlowClk(slow[0]), .bus(bus_a));
  clk_period_meter #(.CNT_W(32), .TIMEOUT(100)) dut_b (
    .clk(clk), .rst(rst), .SlowClk(slow[1]), .bus(bus_b));
  clk_period_meter #(.CNT_W(32), .TIMEOUT(60)) dut_c (
    .clk(clk), .rst(rst), .SlowClk(slow[2]), .bus(bus_c));

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  function automatic logic [31:0] sig(input int i, input int f);
    logic [31:0] r;
    r = '0;
    case (i)
      0: case (f)
           V: r = {31'd0, bus_a.valid};
           B: r = {31'd0, bus_a.busy};
           T: r = {31'd0, bus_a.timeout};
           P: r = bus_a.period;
           default: r = bus_a.high_time;
         endcase
      1: case (f)
           V: r = {31'd0, bus_b.valid};
           B: r = {31'd0, bus_b.busy};
           T: r = {31'd0, bus_b.timeout};
           P: r = bus_b.period;
           default: r = bus_b.high_time;
         endcase
      default: case (f)
           V: r = {31'd0, bus_c.valid};
           B: r = {31'd0, bus_c.busy};
           T: r = {31'd0, bus_c.timeout};
           P: r = bus_c.period;
           default: r = bus_c.high_time;
         endcase
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      if (en[i]) begin
        gen_ph[i] = (gen_ph[i] + 1) % gen_per[i];
        slow[i]   = (gen_ph[i] < gen_hi[i]);
      end else begin
        slow[i] = 1'b0;
      end
    end
  endtask

  task automatic quiet(input int i);
    en[i] = 1'b0;
    repeat (3) tick();
    en[i] = 1'b1;
  endtask

  // Pulse start on the next falling edge with the slow clock forced to phase ph0.
  task automatic launch(input int i, input int ph0);
    tick();
    gen_ph[i]  = ph0;
    slow[i]    = en[i] && (ph0 < gen_hi[i]);
    start_s[i] = 1'b1;
  endtask

  task automatic observe(input int i, input int n, input int ign_at,
                         output int first_v, output int n_v, output int busy_hi);
    first_v = -1;
    n_v     = 0;
    busy_hi = 0;
    for (int t = 1; t <= n; t++) begin
      tick();
      if (t == ign_at) start_s[i] = 1'b1;
      if (sig(i, V) == 32'd1) begin
        n_v++;
        if (first_v < 0) first_v = t;
      end
      if (sig(i, B) == 32'd1) busy_hi++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      slow[i]    = 1'b0;
      start_s[i] = 1'b0;
      en[i]      = 1'b0;
      gen_ph[i]  = 0;
    end
    gen_per[0] = 50; gen_hi[0] = 25;
    gen_per[1] = 10; gen_hi[1] = 3;
    gen_per[2] = 50; gen_hi[2] = 25;

    repeat (3) tick();
    chk("rst_valid",   sig(0, V), 32'd0);
    chk("rst_busy",    sig(0, B), 32'd0);
    chk("rst_timeout", sig(0, T), 32'd0);
    chk("rst_period",  sig(0, P), 32'd0);
    chk("rst_high",    sig(0, H), 32'd0);
    rst = 1'b0;

    // 50/50 slow clock, first high sample 3 edges after start; extra start mid-MEASURE.
    quiet(0);
    launch(0, 47);
    observe(0, 150, 30, fv, nv, bh);
    chk("basic_latency", fv, 32'd56);
    chk("basic_nvalid",  nv, 32'd1);
    chk("basic_busy",    bh, 32'd55);
    chk("basic_period",  sig(0, P), 32'd50);
    chk("basic_high",    sig(0, H), 32'd25);

    // 3-high / 7-low, then a back-to-back start in the cycle after valid.
    gen_per[0] = 10; gen_hi[0] = 3;
    quiet(0);
    launch(0, 7);
    observe(0, 16, 0, fv, nv, bh);
    chk("asym1_latency", fv, 32'd16);
    chk("asym1_busy",    bh, 32'd15);
    chk("asym1_period",  sig(0, P), 32'd10);
    chk("asym1_high",    sig(0, H), 32'd3);
    tick();
    start_s[0] = 1'b1;
    observe(0, 25, 0, fv, nv, bh);
    chk("asym2_latency", fv, 32'd19);
    chk("asym2_nvalid",  nv, 32'd1);
    chk("asym2_period",  sig(0, P), 32'd10);
    chk("asym2_high",    sig(0, H), 32'd3);

    // Meter B: a good measurement, then a stopped clock into a 100-cycle timeout.
    quiet(1);
    launch(1, 7);
    observe(1, 20, 0, fv, nv, bh);
    chk("b_latency", fv, 32'd16);
    chk("b_period",  sig(1, P), 32'd10);
    en[1] = 1'b0;
    launch(1, 0);
    observe(1, 100, 0, fv, nv, bh);
    chk("stop_busy_cycles", bh, 32'd100);
    chk("stop_no_to_yet",   sig(1, T), 32'd0);
    tick();
    chk("stop_timeout",  sig(1, T), 32'd1);
    chk("stop_busy_low", sig(1, B), 32'd0);
    chk("stop_valid",    sig(1, V), 32'd0);
    chk("stop_nvalid",   nv, 32'd0);
    chk("stop_period",   sig(1, P), 32'd10);
    chk("stop_high",     sig(1, H), 32'd3);
    repeat (2) tick();
    chk("stop_sticky", sig(1, T), 32'd1);
    launch(1, 0);
    tick();
    chk("restart_to_clr", sig(1, T), 32'd0);
    chk("restart_busy",   sig(1, B), 32'd1);

    // Meter C: closing edge lands in the last allowed cycle of a 60-cycle budget.
    quiet(2);
    launch(2, 42);
    observe(2, 60, 0, fv, nv, bh);
    chk("tie_nvalid_early", nv, 32'd0);
    chk("tie_busy_cycles",  bh, 32'd60);
    tick();
    chk("tie_valid",   sig(2, V), 32'd1);
    chk("tie_timeout", sig(2, T), 32'd0);
    chk("tie_period",  sig(2, P), 32'd50);
    chk("tie_high",    sig(2, H), 32'd25);
    tick();
    chk("tie_timeout_after", sig(2, T), 32'd0);

    // Asynchronous reset mid-MEASURE on meter A.
    gen_per[0] = 50; gen_hi[0] = 25;
    quiet(0);
    launch(0, 47);
    observe(0, 30, 0, fv, nv, bh);
    chk("pre_rst_busy", sig(0, B), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_busy",    sig(0, B), 32'd0);
    chk("mid_rst_period",  sig(0, P), 32'd0);
    chk("mid_rst_high",    sig(0, H), 32'd0);
    chk("mid_rst_valid",   sig(0, V), 32'd0);
    chk("mid_rst_timeout", sig(0, T), 32'd0);
    chk("mid_rst_b_to",    sig(1, T), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    quiet(0);
    launch(0, 47);
    observe(0, 70, 0, fv, nv, bh);
    chk("post_rst_latency", fv, 32'd56);
    chk("post_rst_nvalid",  nv, 32'd1);
    chk("post_rst_period",  sig(0, P), 32'd50);
    chk("post_rst_high",    sig(0, H), 32'd25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_period_meter.md
# clk_period_meter

Measures the period and high time of a slow, divided clock in units of the system clock, so the slow clocks feeding the MIPS design can be checked in hardware and in simulation. The meter synchronizes the slow clock into the `clk` domain and detects its rising edges. It counts `clk` cycles between two consecutive rising edges and reports the result through a start/valid handshake. A timeout ends any measurement whose slow clock has stopped or is too slow.

## Interface
Parameters:
- `CNT_W`, default 32: width of the cycle counters and result ports.
- `TIMEOUT`, default 1000000: maximum number of `clk` cycles allowed in the ARM and MEASURE states combined, counted per `start`. Must be at least 4 and less than 2^`CNT_W`.

Ports:
- `clk`, input, 1: system clock; all logic is on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `SlowClk`, input, 1: the clock under measurement; treated as asynchronous to `clk`.
- `start`, input, 1: one-cycle request for a measurement; sampled only in IDLE.
- `period`, output, `CNT_W`: measured period in `clk` cycles; holds its value until the next valid result.
- `high_time`, output, `CNT_W`: measured high time in `clk` cycles; holds its value until the next valid result.
- `valid`, output, 1: one-cycle pulse when `period` and `high_time` are updated.
- `busy`, output, 1: high in the ARM and MEASURE states.
- `timeout`, output, 1: sticky error flag; set when a measurement is aborted, cleared by the next accepted `start`.

## Operation
- **Synchronizer:** `SlowClk` passes through a 2-flop synchronizer (s1, s2) and a third flop (s3).
  - `rise = s2 & ~s3`.
  - `lvl = s2`.
- **State machine** with states IDLE, ARM and MEASURE:
  - IDLE: when `start` = 1, clear `timeout`, clear the timeout counter `tcnt`, and go to ARM.
  - ARM: wait for the first `rise`. On `rise`, set `cnt` = 1 and `hcnt` = 1, then go to MEASURE. This first rising edge is never counted as the end of a measurement.
  - MEASURE, cycle with no `rise`: `cnt` increments by 1, and `hcnt` increments by 1 if `lvl` = 1.
  - MEASURE, cycle with `rise`: load `period` <= `cnt` and `high_time` <= `hcnt`, pulse `valid`, and go to IDLE.
- **Timeout:**
  - `tcnt` increments every cycle in ARM and MEASURE.
  - When `tcnt` reaches `TIMEOUT - 1` with no result, set `timeout` = 1, leave `period` and `high_time` unchanged, keep `valid` low, and go to IDLE.
  - If `rise` occurs in MEASURE in the same cycle as the timeout condition, `rise` wins: the result is loaded and `timeout` stays 0.
- **Handshake rules:**
  - `start` is ignored while `busy` = 1.
  - `start` is honoured in the IDLE cycle right after a `valid` pulse, or right after a timeout.
- **Width rules:**
  - `cnt`, `hcnt` and `tcnt` are unsigned, `CNT_W` bits wide.
  - `cnt` and `hcnt` cannot wrap, because the timeout fires before `cnt` exceeds `TIMEOUT`.
- **Results for an ideal input:** for a `SlowClk` that is periodic and synchronous to `clk`, with period P cycles and high time H cycles, the block reports `period` = P and `high_time` = H exactly. Asynchronous inputs are accurate to ±1 cycle.
- **Reset:** `rst` (asynchronous) forces the following, even mid-measurement:
  - state = IDLE, s1 = s2 = s3 = 0;
  - `cnt` = `hcnt` = `tcnt` = 0;
  - `period` = 0, `high_time` = 0, `valid` = 0, `busy` = 0, `timeout` = 0.
- **Power-up case:** if `SlowClk` is already high when reset is released, s3 = 0, so a `rise` occurs 2 cycles later. This is acceptable because IDLE ignores `rise`.

## Timing
- Edge-detect latency: a `SlowClk` rising edge first sampled high at `clk` edge k makes `rise` = 1 during the cycle after edge k+1.
- `busy` rises on the clock edge that samples `start` in IDLE.
- `valid` and the updated result registers appear together, 1 cycle after the terminating `rise` is sampled. `busy` falls on that same edge.
- Total latency from `start` to `valid` is at most 2·P + 3 cycles: up to one P spent waiting in ARM, plus one full P in MEASURE, plus synchronizer latency.
- On timeout, `timeout` = 1 and `busy` = 0 are asserted on the same edge, `TIMEOUT` cycles after the `start` edge.

## Test plan
- **Basic measurement:** `clk` period 20 ns; `SlowClk` toggles every 25 `clk` cycles; pulse `start` -> `valid` pulses once with `period` = 50 and `high_time` = 25. `busy` is high from `start` to `valid`.
- **Asymmetric duty cycle:** `SlowClk` high for 3 cycles and low for 7 cycles -> `period` = 10, `high_time` = 3. Two back-to-back `start` requests, each issued in the cycle after `valid`, both return the same values.
- **Stopped clock:** `SlowClk` held at 0, `TIMEOUT` = 100 -> `timeout` = 1 at cycle 100 after `start`, no `valid` pulse, and `period` / `high_time` keep their previous values. The next `start` clears `timeout`.
- **Ignored start:** pulse `start` again during MEASURE -> ignored; exactly one `valid` pulse results.
- **Reset mid-measurement:** assert `rst` mid-MEASURE, asynchronously between `clk` edges -> all outputs are 0 immediately. After release, `start` produces a correct measurement.
- **Timeout/rise tie:** with `TIMEOUT` = 60, `SlowClk` period = 50 and a phase chosen so that `rise` coincides with the timeout cycle -> `valid` = 1, `period` = 50, `timeout` = 0.
